fir_stream_ctrl: RTL and testbench

FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

---
 rtl/fir_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Streaming controller for a fixed-latency FIR datapath: credit-based input handshake,
// tag pipe aligning results, output FIFO, and delay-line flush. Macro FIR_STREAM_CTRL_PRIME_EN makes reset exit into FLUSH.
module fir_stream_ctrl #(
    parameter int LAT        = 4,
    parameter int TAPS       = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        fir_ce,
    output logic [15:0] fir_in,
    input  logic [15:0] fir_out,
    input  logic        flush,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + LAT + 1);
    localparam int FW = $clog2(TAPS + LAT + 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

`ifdef FIR_STREAM_CTRL_PRIME_EN
    localparam state_t RESET_STATE = FLUSH;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t          state;
    logic [FW-1:0]   fcnt;
    logic            busy_q;
    logic [LAT-1:0]  tag;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic            accept;
    logic            push;
    logic            pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag[i]);
        end
    end

    // Credit covers results still in the pipe, so every tagged result finds a FIFO slot.
    assign s_ready = rst_n && (state == RUN) && !flush &&
                     ((inflight + count) < CW'(FIFO_DEPTH));
    assign accept  = s_valid && s_ready;

    always_comb begin
        fir_ce = 1'b0;
        fir_in = '0;
        if (state == RUN) begin
            fir_ce = accept;
            fir_in = accept ? s_data : '0;
        end else if (rst_n && (fcnt < FW'(TAPS))) begin
            fir_ce = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RESET_STATE;
            fcnt   <= '0;
            busy_q <= (RESET_STATE == FLUSH);
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        state  <= FLUSH;
                        fcnt   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fcnt == FW'(TAPS + LAT - 1)) begin
                        state  <= RUN;
                        fcnt   <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = rst_n && busy_q;

    // Tag exits the last stage in the same cycle the datapath presents the matching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else begin
            tag[0] <= accept;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    assign push = tag[LAT-1];
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fir_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_valid = rst_n && (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl; the filter datapath is modelled as a LAT-stage
// register chain whose output is the delayed fir_in XOR 16'h1234.
module tb_fir_stream_ctrl;

    localparam int LAT   = 4;
    localparam int TAPS  = 9;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        fir_ce;
    logic [15:0] fir_in;
    logic [15:0] fir_out;
    logic        flush;
    logic        busy;

    always #5 clk = ~clk;

    fir_stream_ctrl #(
        .LAT       (LAT),
        .TAPS      (TAPS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .fir_ce (fir_ce),
        .fir_in (fir_in),
        .fir_out(fir_out),
        .flush  (flush),
        .busy   (busy)
    );

    logic [15:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fir_in;
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fir_out = fpipe[LAT-1] ^ 16'h1234;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          delivered;
    int          cyc;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1ns later, score any pop.
    task automatic step(input logic sv, input logic [15:0] sd, input logic mr, input logic fl,
                        output logic rdy, output logic ce, output logic [15:0] fi,
                        output logic mv, output logic bz);
        logic [15:0] e;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        #1;
        rdy = s_ready;
        ce  = fir_ce;
        fi  = fir_in;
        mv  = m_valid;
        bz  = busy;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_m_valid", 32'(m_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(e));
                delivered++;
            end
        end
        if (sv && rdy) exp_q.push_back(sd ^ 16'h1234);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed incomplete run, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy, ce, mv, bz;
        logic [15:0] fi;
        int          first_ce, first_mv, acc, n, ce_cnt, nz, bz_cnt;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;
        delivered = 0; cyc = 0;

        // Reset: outputs held quiet even with traffic offered
        @(negedge clk);
        s_valid = 1'b1; s_data = 16'hABCD; m_ready = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_fir_ce",  32'(fir_ce),  32'd0);
        check("rst_fir_in",  32'(fir_in),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b1;
        #1;
`ifdef FIR_STREAM_CTRL_PRIME_EN
        check("prime_busy_after_reset", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("prime_busy_cycles", 32'(n), 32'(TAPS + LAT));
`else
        check("busy_after_reset", 32'(busy), 32'd0);
        check("s_ready_after_reset", 32'(s_ready), 32'd1);
`endif
        @(negedge clk);

        // Streaming: 20 back-to-back samples
        first_ce = -1; first_mv = -1; delivered = 0;
        for (int i = 0; i < 20; i++) begin
            n = cyc;
            step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, rdy, ce, fi, mv, bz);
            check("stream_s_ready", 32'(rdy), 32'd1);
            if (i == 0) check("stream_first_fir_in", 32'(fi), 32'h0100);
            if (ce && first_ce < 0) first_ce = n;
            if (mv && first_mv < 0) first_mv = n;
        end
        for (int i = 0; i < 20 && delivered < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        check("stream_delivered", 32'(delivered), 32'd20);
        check("stream_mvalid_edges_after_ce", 32'(first_mv - first_ce - 1), 32'(LAT));

        // Backpressure: credit stops acceptance at FIFO_DEPTH
        delivered = 0; acc = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 16'h0200 + 16'(acc), 1'b0, 1'b0, rdy, ce, fi, mv, bz);
            if (rdy) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd8);
        check("bp_s_ready_low", 32'(rdy), 32'd0);
        check("bp_m_valid", 32'(mv), 32'd1);
        for (int i = 0; i < 20 && delivered < 8; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        check("bp_delivered", 32'(delivered), 32'd8);
        delivered = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0, rdy, ce, fi, mv, bz);
            check("resume_s_ready", 32'(rdy), 32'd1);
        end
        for (int i = 0; i < 20 && delivered < 6; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        check("resume_delivered", 32'(delivered), 32'd6);

        // Flush with three samples in flight
        delivered = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0400 + 16'(i), 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        step(1'b0, 16'h0, 1'b1, 1'b1, rdy, ce, fi, mv, bz);
        check("flush_req_s_ready", 32'(rdy), 32'd0);
        check("flush_req_busy", 32'(bz), 32'd0);
        ce_cnt = 0; nz = 0; bz_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
            if (ce) ce_cnt++;
            if (ce && fi != 16'h0) nz++;
            if (bz) bz_cnt++;
        end
        check("flush_fir_ce_cycles", 32'(ce_cnt), 32'(TAPS));
        check("flush_fir_in_nonzero", 32'(nz), 32'd0);
        check("flush_busy_cycles", 32'(bz_cnt), 32'(TAPS + LAT));
        check("flush_delivered", 32'(delivered), 32'd3);
        check("flush_queue_empty", 32'(exp_q.size()), 32'd0);

        // Collision: flush wins over s_valid
        step(1'b1, 16'h7777, 1'b1, 1'b1, rdy, ce, fi, mv, bz);
        check("collide_s_ready", 32'(rdy), 32'd0);
        check("collide_fir_ce", 32'(ce), 32'd0);
        check("collide_not_accepted", 32'(exp_q.size()), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        check("collide_busy", 32'(bz), 32'd1);
        for (int i = 0; i < 20 && bz; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        check("collide_flush_done", 32'(bz), 32'd0);

        // Mid-operation reset with 5 entries queued
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0, rdy, ce, fi, mv, bz);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0, rdy, ce, fi, mv, bz);
        end
        #1;
        check("pre_reset_m_valid", 32'(m_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
`ifdef FIR_STREAM_CTRL_PRIME_EN
        check("post_rst_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("post_rst_prime_cycles", 32'(n), 32'(TAPS + LAT));
`else
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
`endif
        @(negedge clk);
        delivered = 0;
        step(1'b1, 16'h0600, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        check("post_rst_accept", 32'(rdy), 32'd1);
        for (int i = 0; i < 20 && delivered < 1; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, rdy, ce, fi, mv, bz);
        end
        check("post_rst_delivered", 32'(delivered), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
